// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scanner with a double-buffered display word.
// Optional leading-zero suppression: define DIGIT_LZ_BLANK_EN.
module digit_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dispEnable,
  input  logic                    loadValid,
  output logic                    loadReady,
  input  logic [4*NUM_DIGITS-1:0] loadData,
  output logic [3:0]              segNibble,
  output logic                    segEnable,
  output logic [NUM_DIGITS-1:0]   digitSel,
  output logic                    frameTick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;
  localparam logic [1:0] S_FIRST =
    (BLANK_CYCLES > 0) ? S_BLANK : S_SHOW;

  logic [1:0]              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pend_full_q, pend_full_d;

  logic [3:0]              seg_nibble_q, seg_nibble_d;
  logic                    seg_enable_q, seg_enable_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    accept;
  logic                    copy;
  logic                    show_d;
  logic                    lit_d;
  logic [NUM_DIGITS-1:0]   keep;
  logic                    any_nz;

  assign loadReady = ~pend_full_q;
  assign accept    = loadValid & ~pend_full_q;

  // Scan sequencer: slot counter, digit index and state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    copy    = 1'b0;
    if (state_q == S_IDLE) begin
      copy  = pend_full_q;
      idx_d = '0;
      cnt_d = '0;
      if (dispEnable) begin
        state_d = S_FIRST;
      end
    end else if (!dispEnable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLK_LAST) begin
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_d   = '0;
            state_d = S_FIRST;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              copy  = pend_full_q;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Copy and accept never coincide: copy needs pend_full_q, accept its inverse.
  always_comb begin
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    if (copy) begin
      active_d    = pending_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pending_d   = loadData;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    keep   = '1;
    any_nz = 1'b0;
`ifdef DIGIT_LZ_BLANK_EN
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      any_nz  = any_nz | (|active_d[4*k +: 4]);
      keep[k] = any_nz;
    end
    keep[0] = 1'b1;
`endif
  end

  // Outputs are registered from next-state values so they align with state.
  always_comb begin
    show_d       = (state_d == S_SHOW);
    seg_nibble_d = '0;
    digit_sel_d  = '0;
    lit_d        = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        if (state_d != S_IDLE) begin
          seg_nibble_d = active_d[4*k +: 4];
        end
        digit_sel_d[k] = show_d;
        lit_d          = keep[k];
      end
    end
    seg_enable_d = show_d & lit_d;
    frame_tick_d = show_d && (cnt_d == SLOT_LAST)
                   && (idx_d == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_full_q  <= 1'b0;
      seg_nibble_q <= '0;
      seg_enable_q <= 1'b0;
      digit_sel_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_full_q  <= pend_full_d;
      seg_nibble_q <= seg_nibble_d;
      seg_enable_q <= seg_enable_d;
      digit_sel_q  <= digit_sel_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign segNibble = seg_nibble_q;
  assign segEnable = seg_enable_q;
  assign digitSel  = digit_sel_q;
  assign frameTick = frame_tick_q;

endmodule
